uarc_send_sequencer: RTL and testbench

Sequences one outgoing UARC bus operation (kill, incept, send or stream) from the core onto a set of selected buses. The block drives the shared global strobe and data lines and the per-bus sender enables. It collects the per-bus acknowledges, retires each bus as soon as it acks, and reports completion or a timeout fault. It sits between core0's instruction-level UARC logic and the sender_* / global_* bus pins.

---
 rtl/uarc_send_if.sv | 43 ++++
 rtl/uarc_send_sequencer.sv | 131 +++++++++++++
 tb/tb_uarc_send_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uarc_send_if.sv
// Core-to-sequencer request plus global/sender bus pins for one UARC send sequencer.
// slave = the sequencer; master = the core and bus side that drives requests and acks.
interface uarc_send_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int TOTAL_BUSES = 4
);
    logic                   op_valid;
    logic                   op_ready;
    logic [1:0]             op_kind;
    logic [TOTAL_BUSES-1:0] op_mask;
    logic [WORD_WIDTH-1:0]  op_data;

    logic                   global_kill;
    logic                   global_incept;
    logic                   global_send;
    logic                   global_stream;
    logic [WORD_WIDTH-1:0]  global_data;

    logic [TOTAL_BUSES-1:0] sender_enables;
    logic [TOTAL_BUSES-1:0] sender_kill_acks;
    logic [TOTAL_BUSES-1:0] sender_incept_acks;
    logic [TOTAL_BUSES-1:0] sender_send_acks;
    logic [TOTAL_BUSES-1:0] sender_stream_acks;

    logic                   busy;
    logic                   done;
    logic                   fault;
    logic [TOTAL_BUSES-1:0] fault_mask;

    modport master (
        output op_valid, op_kind, op_mask, op_data,
        output sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
        input  op_ready, global_kill, global_incept, global_send, global_stream, global_data,
        input  sender_enables, busy, done, fault, fault_mask
    );

    modport slave (
        input  op_valid, op_kind, op_mask, op_data,
        input  sender_kill_acks, sender_incept_acks, sender_send_acks, sender_stream_acks,
        output op_ready, global_kill, global_incept, global_send, global_stream, global_data,
        output sender_enables, busy, done, fault, fault_mask
    );
endinterface

// File: rtl/uarc_send_sequencer.sv
// Drives one UARC kill/incept/send/stream operation onto the selected buses, retiring
// each bus on its ack and reporting done or a timeout fault.
module uarc_send_sequencer #(
    parameter int WORD_MAG       = 5,
    parameter int TOTAL_BUSES    = 4,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    uarc_send_if.slave bus
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;
    localparam logic [1:0] KIND_KILL   = 2'd0;
    localparam logic [1:0] KIND_INCEPT = 2'd1;
    localparam logic [1:0] KIND_SEND   = 2'd2;
    localparam logic [1:0] KIND_STREAM = 2'd3;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                   state_reg, state_next;
    logic [TOTAL_BUSES-1:0]   pending_reg, pending_next;
    logic [1:0]               kind_reg, kind_next;
    logic [WORD_WIDTH-1:0]    data_reg, data_next;
    logic [TIMEOUT_WIDTH-1:0] counter_reg, counter_next;
    logic [TOTAL_BUSES-1:0]   fault_mask_reg, fault_mask_next;
    logic                     done_reg, done_next;
    logic                     fault_reg, fault_next;

    logic [TOTAL_BUSES-1:0]   ackv;
    logic [TOTAL_BUSES-1:0]   rem;

    // Only the ack family matching the latched kind can retire a bus.
    generate
        for (genvar gi = 0; gi < TOTAL_BUSES; gi++) begin : g_ack_sel
            always_comb begin
                case (kind_reg)
                    KIND_KILL:   ackv[gi] = bus.sender_kill_acks[gi];
                    KIND_INCEPT: ackv[gi] = bus.sender_incept_acks[gi];
                    KIND_SEND:   ackv[gi] = bus.sender_send_acks[gi];
                    default:     ackv[gi] = bus.sender_stream_acks[gi];
                endcase
            end
        end
    endgenerate

    assign rem = pending_reg & ~ackv;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pending_reg    <= '0;
            kind_reg       <= '0;
            data_reg       <= '0;
            counter_reg    <= '0;
            fault_mask_reg <= '0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            kind_reg       <= kind_next;
            data_reg       <= data_next;
            counter_reg    <= counter_next;
            fault_mask_reg <= fault_mask_next;
            done_reg       <= done_next;
            fault_reg      <= fault_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pending_next    = pending_reg;
        kind_next       = kind_reg;
        data_next       = data_reg;
        counter_next    = counter_reg;
        fault_mask_next = fault_mask_reg;
        done_next       = 1'b0;
        fault_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.op_valid) begin
                    kind_next    = bus.op_kind;
                    data_next    = bus.op_data;
                    pending_next = bus.op_mask;
                    counter_next = '0;
                    // An empty mask completes without ever touching the bus.
                    if (|bus.op_mask) state_next = ACTIVE;
                    else              done_next  = 1'b1;
                end
            end
            ACTIVE: begin
                pending_next = rem;
                if (rem == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (TIMEOUT_EN && counter_reg == TIMEOUT_LAST) begin
                    state_next      = IDLE;
                    fault_next      = 1'b1;
                    fault_mask_next = rem;
                    pending_next    = '0;
                end else if (counter_reg != {TIMEOUT_WIDTH{1'b1}}) begin
                    counter_next = counter_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic active;
    assign active = (state_reg == ACTIVE);

    assign bus.op_ready       = (state_reg == IDLE);
    assign bus.busy           = active;
    assign bus.sender_enables = active ? pending_reg : '0;
    assign bus.global_kill    = active && (kind_reg == KIND_KILL);
    assign bus.global_incept  = active && (kind_reg == KIND_INCEPT);
    assign bus.global_send    = active && (kind_reg == KIND_SEND);
    assign bus.global_stream  = active && (kind_reg == KIND_STREAM);
    assign bus.global_data    = data_reg;
    assign bus.done           = done_reg;
    assign bus.fault          = fault_reg;
    assign bus.fault_mask     = fault_mask_reg;
endmodule

// File: tb/tb_uarc_send_sequencer.sv
// Directed bench for uarc_send_sequencer with a 4-cycle timeout.
module tb_uarc_send_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_passed = 0;

    uarc_send_if #(.WORD_WIDTH(32), .TOTAL_BUSES(4)) bus_if ();

    uarc_send_sequencer #(
        .WORD_MAG(5), .TOTAL_BUSES(4), .TIMEOUT_WIDTH(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
            $display("ok   %-22s got=%08h", tag, got);
        end else begin
            $display("FAIL %-22s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [3:0] mask, input logic [31:0] data);
        bus_if.op_valid = 1'b1;
        bus_if.op_kind  = kind;
        bus_if.op_mask  = mask;
        bus_if.op_data  = data;
        tick();
        bus_if.op_valid = 1'b0;
    endtask

    function automatic logic [3:0] strobes();
        return {bus_if.global_stream, bus_if.global_send, bus_if.global_incept, bus_if.global_kill};
    endfunction

    initial begin
        reset = 1'b1;
        bus_if.op_valid = 1'b0;
        bus_if.op_kind  = 2'd0;
        bus_if.op_mask  = 4'd0;
        bus_if.op_data  = 32'd0;
        bus_if.sender_kill_acks   = 4'd0;
        bus_if.sender_incept_acks = 4'd0;
        bus_if.sender_send_acks   = 4'd0;
        bus_if.sender_stream_acks = 4'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Reset / idle
        check("rst_op_ready", 32'(bus_if.op_ready), 32'd1);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done_fault", 32'({bus_if.done, bus_if.fault}), 32'd0);
        check("rst_enables", 32'(bus_if.sender_enables), 32'd0);
        check("rst_data", bus_if.global_data, 32'd0);
        check("rst_fault_mask", 32'(bus_if.fault_mask), 32'd0);

        // Send: acks 0001 at cycle 2, 1010 at cycle 4 (the timeout cycle)
        issue(2'd2, 4'b1011, 32'hDEADBEEF);
        check("send_c1_strobes", 32'(strobes()), 32'b0100);
        check("send_c1_data", bus_if.global_data, 32'hDEADBEEF);
        check("send_c1_enables", 32'(bus_if.sender_enables), 32'b1011);
        check("send_c1_busy_ready", 32'({bus_if.busy, bus_if.op_ready}), 32'b10);
        tick();
        bus_if.sender_send_acks = 4'b0001;
        check("send_c2_enables", 32'(bus_if.sender_enables), 32'b1011);
        tick();
        bus_if.sender_send_acks = 4'b0000;
        check("send_c3_enables", 32'(bus_if.sender_enables), 32'b1010);
        tick();
        bus_if.sender_send_acks = 4'b1010;
        check("send_c4_done", 32'(bus_if.done), 32'd0);
        tick();
        bus_if.sender_send_acks = 4'b0000;
        check("send_c5_done", 32'(bus_if.done), 32'd1);
        check("send_c5_fault", 32'(bus_if.fault), 32'd0);
        check("send_c5_ready", 32'(bus_if.op_ready), 32'd1);
        check("send_c5_enables", 32'(bus_if.sender_enables), 32'd0);
        check("send_c5_strobes", 32'(strobes()), 32'd0);
        check("send_c5_data_hold", bus_if.global_data, 32'hDEADBEEF);
        tick();
        check("send_c6_done_low", 32'(bus_if.done), 32'd0);

        // Kill timeout: only bus 0 acks with the right kind
        bus_if.sender_send_acks = 4'b0011;
        bus_if.sender_kill_acks = 4'b0001;
        issue(2'd0, 4'b0011, 32'h12345678);
        check("kill_c1_strobes", 32'(strobes()), 32'b0001);
        check("kill_c1_enables", 32'(bus_if.sender_enables), 32'b0011);
        tick();
        check("kill_c2_enables", 32'(bus_if.sender_enables), 32'b0010);
        tick(); tick();
        check("kill_c4_strobes", 32'(strobes()), 32'b0001);
        check("kill_c4_fault", 32'(bus_if.fault), 32'd0);
        tick();
        bus_if.sender_send_acks = 4'b0000;
        bus_if.sender_kill_acks = 4'b0000;
        check("kill_c5_fault", 32'(bus_if.fault), 32'd1);
        check("kill_c5_done", 32'(bus_if.done), 32'd0);
        check("kill_c5_fault_mask", 32'(bus_if.fault_mask), 32'b0010);
        check("kill_c5_ready", 32'(bus_if.op_ready), 32'd1);
        check("kill_c5_strobes", 32'(strobes()), 32'd0);
        tick();
        check("kill_c6_fault_low", 32'(bus_if.fault), 32'd0);
        check("kill_c6_mask_hold", 32'(bus_if.fault_mask), 32'b0010);

        // Incept with empty mask
        issue(2'd1, 4'b0000, 32'hCAFEF00D);
        check("incept_c1_done", 32'(bus_if.done), 32'd1);
        check("incept_c1_busy", 32'(bus_if.busy), 32'd0);
        check("incept_c1_strobes", 32'(strobes()), 32'd0);
        check("incept_c1_enables", 32'(bus_if.sender_enables), 32'd0);
        tick();
        check("incept_c2_done_low", 32'(bus_if.done), 32'd0);

        // Stream: all acks land in the counter==3 cycle, completion beats timeout
        issue(2'd3, 4'b1111, 32'h0F0F0F0F);
        check("stream_c1_strobes", 32'(strobes()), 32'b1000);
        tick(); tick(); tick();
        bus_if.sender_stream_acks = 4'b1111;
        check("stream_c4_enables", 32'(bus_if.sender_enables), 32'b1111);
        tick();
        bus_if.sender_stream_acks = 4'b0000;
        check("stream_c5_done", 32'(bus_if.done), 32'd1);
        check("stream_c5_fault", 32'(bus_if.fault), 32'd0);
        check("stream_c5_mask_hold", 32'(bus_if.fault_mask), 32'b0010);

        // Reset mid-ACTIVE
        tick();
        issue(2'd2, 4'b0100, 32'hA5A5A5A5);
        check("rstmid_c1_busy", 32'(bus_if.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_strobes", 32'(strobes()), 32'd0);
        check("rstmid_enables", 32'(bus_if.sender_enables), 32'd0);
        check("rstmid_ready", 32'(bus_if.op_ready), 32'd1);
        check("rstmid_data", bus_if.global_data, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rstmid_quiet_%0d", i), 32'({bus_if.done, bus_if.fault, bus_if.busy}), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
